// File: rtl/vga_timing_gen_if.sv
// ----------------------------------------------------------------------------
// vga_timing_gen_if
// Raster timing bundle between the VGA timing generator (master) and the
// downstream draw logic (slave).
//   enable      : slave -> master, run the raster (0 freezes position)
//   pix_en      : one-clock strobe, all other signals carry a new pixel
//   hcount      : current pixel column
//   vcount      : current line
//   hsync/vsync : sync pulses, polarity set by the generator
//   hblnk/vblnk : horizontal / vertical blanking
//   active      : visible pixel (!hblnk && !vblnk)
//   line_start  : with pix_en, first pixel of a line
//   frame_start : with pix_en, first pixel of a frame
//   frame_cnt   : completed-frame counter
// ----------------------------------------------------------------------------
interface vga_timing_gen_if;
    logic        enable;
    logic        pix_en;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic        active;
    logic        line_start;
    logic        frame_start;
    logic [15:0] frame_cnt;

    modport master (
        input  enable,
        output pix_en, hcount, vcount, hsync, vsync, hblnk, vblnk,
               active, line_start, frame_start, frame_cnt
    );

    modport slave (
        output enable,
        input  pix_en, hcount, vcount, hsync, vsync, hblnk, vblnk,
               active, line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
// VGA raster timing generator. A clock divider produces one pixel tick every
// CLK_DIV cycles of ACLK while enabled; each tick advances the h/v position
// and registers every timing output from the new position, so outputs appear
// one ACLK after the tick together with a one-cycle pix_en strobe.
// Ports:
//   ACLK    : system clock
//   ARESETN : asynchronous active-low reset
//   vga     : vga_timing_gen_if.master (enable in, timing outputs out)
// ----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4,
    parameter int SYNC_POL = 0
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [10:0]      H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0]      V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0]      H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0]      V_VIS    = 11'(V_ACTIVE);
    localparam logic [10:0]      HS_FIRST = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0]      HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0]      VS_FIRST = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0]      VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic             SYNC_ON  = (SYNC_POL != 0) ? 1'b1 : 1'b0;

    // Internal position and divider
    logic [DIV_W-1:0] div_reg, div_next;
    logic [10:0]      h_reg, h_next;
    logic [10:0]      v_reg, v_next;
    logic             tick;
    logic             h_wrap;

    // Registered outputs
    logic        pix_en_reg;
    logic [10:0] hcount_reg;
    logic [10:0] vcount_reg;
    logic        hsync_reg, hsync_next;
    logic        vsync_reg, vsync_next;
    logic        hblnk_reg, hblnk_next;
    logic        vblnk_reg, vblnk_next;
    logic        active_reg;
    logic        line_start_reg, line_start_next;
    logic        frame_start_reg, frame_start_next;
    logic [15:0] frame_cnt_reg;
    // Set by the first frame_start after reset; that frame is not "completed"
    logic        started_reg;

    always_comb begin
        tick     = vga.enable && (div_reg == DIV_LAST);
        div_next = '0;
        if (vga.enable && (div_reg != DIV_LAST)) begin
            div_next = div_reg + 1'b1;
        end

        h_wrap = (h_reg == H_LAST);
        h_next = h_wrap ? 11'd0 : h_reg + 11'd1;
        v_next = v_reg;
        if (h_wrap) begin
            v_next = (v_reg == V_LAST) ? 11'd0 : v_reg + 11'd1;
        end

        // Decode from the position the tick moves to, not the current one
        hsync_next       = ((h_next >= HS_FIRST) && (h_next <= HS_LAST)) ? SYNC_ON : ~SYNC_ON;
        vsync_next       = ((v_next >= VS_FIRST) && (v_next <= VS_LAST)) ? SYNC_ON : ~SYNC_ON;
        hblnk_next       = (h_next >= H_VIS);
        vblnk_next       = (v_next >= V_VIS);
        line_start_next  = (h_next == 11'd0);
        frame_start_next = (h_next == 11'd0) && (v_next == 11'd0);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            div_reg         <= '0;
            h_reg           <= H_LAST;
            v_reg           <= V_LAST;
            pix_en_reg      <= 1'b0;
            hcount_reg      <= 11'd0;
            vcount_reg      <= 11'd0;
            hsync_reg       <= ~SYNC_ON;
            vsync_reg       <= ~SYNC_ON;
            hblnk_reg       <= 1'b0;
            vblnk_reg       <= 1'b0;
            active_reg      <= 1'b0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            frame_cnt_reg   <= 16'd0;
            started_reg     <= 1'b0;
        end else begin
            div_reg         <= div_next;
            // Strobes only live for the cycle after a tick
            pix_en_reg      <= tick;
            line_start_reg  <= tick && line_start_next;
            frame_start_reg <= tick && frame_start_next;
            if (tick) begin
                h_reg      <= h_next;
                v_reg      <= v_next;
                hcount_reg <= h_next;
                vcount_reg <= v_next;
                hsync_reg  <= hsync_next;
                vsync_reg  <= vsync_next;
                hblnk_reg  <= hblnk_next;
                vblnk_reg  <= vblnk_next;
                active_reg <= !hblnk_next && !vblnk_next;
                if (frame_start_next) begin
                    started_reg <= 1'b1;
                    if (started_reg) begin
                        frame_cnt_reg <= frame_cnt_reg + 16'd1;
                    end
                end
            end
        end
    end

    assign vga.pix_en      = pix_en_reg;
    assign vga.hcount      = hcount_reg;
    assign vga.vcount      = vcount_reg;
    assign vga.hsync       = hsync_reg;
    assign vga.vsync       = vsync_reg;
    assign vga.hblnk       = hblnk_reg;
    assign vga.vblnk       = vblnk_reg;
    assign vga.active      = active_reg;
    assign vga.line_start  = line_start_reg;
    assign vga.frame_start = frame_start_reg;
    assign vga.frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
// Two generator instances on a reduced raster (24 x 10 total) so full frames
// fit in a short run: instance 0 with CLK_DIV=4 / active-low syncs, instance 1
// with CLK_DIV=1 / active-high syncs. A reference model pushes the expected
// pixel record on every predicted tick; the checker pops it on the following
// cycle and compares every output, every cycle.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int HA  = 16;
    localparam int HFP = 2;
    localparam int HS  = 3;
    localparam int HBP = 3;
    localparam int VA  = 6;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 1;
    localparam int HT  = HA + HFP + HS + HBP;   // 24
    localparam int VT  = VA + VFP + VS + VBP;   // 10

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic        act;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } exp_t;

    logic ACLK;
    logic ARESETN;
    logic enable;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int CD  = (gi == 0) ? 4 : 1;
        localparam int POL = (gi == 0) ? 0 : 1;
        localparam logic ON = (POL != 0) ? 1'b1 : 1'b0;

        vga_timing_gen_if vif ();
        assign vif.enable = enable;

        vga_timing_gen #(
            .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
            .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
            .CLK_DIV(CD), .SYNC_POL(POL)
        ) dut (
            .ACLK   (ACLK),
            .ARESETN(ARESETN),
            .vga    (vif.master)
        );

        exp_t q[$];
        exp_t last;
        exp_t rst_rec;
        int   m_div, m_h, m_v, m_fc;
        bit   m_seen;
        int   pe_cnt = 0, fs_cnt = 0, vs_cnt = 0, ls_cnt = 0;

        // Reference model: predicts ticks and the pixel record they produce
        always @(posedge ACLK or negedge ARESETN) begin
            exp_t e;
            if (!ARESETN) begin
                m_div  = 0;
                m_h    = HT - 1;
                m_v    = VT - 1;
                m_fc   = 0;
                m_seen = 0;
                q.delete();
            end else if (!enable) begin
                m_div = 0;
            end else if (m_div == CD - 1) begin
                m_div = 0;
                if (m_h == HT - 1) begin
                    m_h = 0;
                    m_v = (m_v == VT - 1) ? 0 : m_v + 1;
                end else begin
                    m_h = m_h + 1;
                end
                e.h   = 11'(m_h);
                e.v   = 11'(m_v);
                e.hs  = (m_h >= HA + HFP && m_h < HA + HFP + HS) ? ON : ~ON;
                e.vs  = (m_v >= VA + VFP && m_v < VA + VFP + VS) ? ON : ~ON;
                e.hb  = (m_h >= HA);
                e.vb  = (m_v >= VA);
                e.act = (m_h < HA) && (m_v < VA);
                e.ls  = (m_h == 0);
                e.fs  = (m_h == 0) && (m_v == 0);
                if (e.fs) begin
                    if (m_seen) m_fc = (m_fc + 1) & 16'hFFFF;
                    m_seen = 1;
                end
                e.fc = 16'(m_fc);
                q.push_back(e);
            end else begin
                m_div = m_div + 1;
            end
        end

        // Checker: every output, every cycle, away from the active edge
        always @(negedge ACLK) begin
            exp_t e;
            logic pe;
            rst_rec = '{h: 11'd0, v: 11'd0, hs: ~ON, vs: ~ON, hb: 1'b0, vb: 1'b0,
                        act: 1'b0, ls: 1'b0, fs: 1'b0, fc: 16'd0};
            if (!ARESETN) begin
                last = rst_rec;
                e    = rst_rec;
                pe   = 1'b0;
            end else if (q.size() > 0) begin
                e       = q.pop_front();
                pe      = 1'b1;
                last    = e;
                last.ls = 1'b0;
                last.fs = 1'b0;
            end else begin
                e  = last;
                pe = 1'b0;
            end
            check($sformatf("d%0d pix_en", gi), 32'(vif.pix_en), 32'(pe));
            check($sformatf("d%0d hcount", gi), 32'(vif.hcount), 32'(e.h));
            check($sformatf("d%0d vcount", gi), 32'(vif.vcount), 32'(e.v));
            check($sformatf("d%0d flags{hs,vs,hb,vb,act,ls,fs}", gi),
                  32'({vif.hsync, vif.vsync, vif.hblnk, vif.vblnk, vif.active,
                       vif.line_start, vif.frame_start}),
                  32'({e.hs, e.vs, e.hb, e.vb, e.act, e.ls, e.fs}));
            check($sformatf("d%0d frame_cnt", gi), 32'(vif.frame_cnt), 32'(e.fc));
            if (ARESETN && vif.pix_en) begin
                pe_cnt++;
                if (vif.frame_start) fs_cnt++;
                if (vif.line_start)  ls_cnt++;
                if (vif.vsync == ON) vs_cnt++;
            end
        end
    end

    task automatic wait_pix(input int h, input int v, input int limit);
        bit found;
        found = 0;
        for (int k = 0; k < limit && !found; k++) begin
            @(negedge ACLK);
            if (g_dut[0].vif.pix_en && g_dut[0].vif.hcount == 11'(h) &&
                g_dut[0].vif.vcount == 11'(v)) found = 1;
        end
        check($sformatf("wait h=%0d v=%0d found", h, v), 32'(found), 32'd1);
    endtask

    initial begin
        int k;
        ARESETN = 1'b0;
        enable  = 1'b0;
        repeat (4) @(negedge ACLK);
        #2 ARESETN = 1'b1;
        repeat (3) @(negedge ACLK);

        // Two full frames of instance 0 (480 ticks x 4 cycles)
        enable = 1'b1;
        repeat (1920) @(negedge ACLK);
        #1;
        $display("two-frame run: d0 fs=%0d ls=%0d vs=%0d fc=%0d, d1 pe=%0d fc=%0d",
                 g_dut[0].fs_cnt, g_dut[0].ls_cnt, g_dut[0].vs_cnt,
                 g_dut[0].vif.frame_cnt, g_dut[1].pe_cnt, g_dut[1].vif.frame_cnt);
        check("d0 frame_start count", 32'(g_dut[0].fs_cnt), 32'd2);
        check("d0 line_start count",  32'(g_dut[0].ls_cnt), 32'(2 * VT));
        check("d0 vsync tick count",  32'(g_dut[0].vs_cnt), 32'(2 * VS * HT));
        check("d0 frame_cnt",         32'(g_dut[0].vif.frame_cnt), 32'd1);
        check("d1 pix_en count",      32'(g_dut[1].pe_cnt), 32'd1920);
        check("d1 frame_cnt",         32'(g_dut[1].vif.frame_cnt), 32'd7);

        // Freeze at h=10, v=3 for 50 cycles, then resume
        wait_pix(10, 3, 2000);
        enable = 1'b0;
        repeat (50) @(negedge ACLK);
        $display("enable drop: held hcount=%0d vcount=%0d", g_dut[0].vif.hcount, g_dut[0].vif.vcount);
        check("hold hcount", 32'(g_dut[0].vif.hcount), 32'd10);
        check("hold vcount", 32'(g_dut[0].vif.vcount), 32'd3);
        enable = 1'b1;
        k = 0;
        for (int i = 1; i <= 20 && k == 0; i++) begin
            @(negedge ACLK);
            if (g_dut[0].vif.pix_en) k = i;
        end
        $display("re-enable: first pix_en after %0d cycles, hcount=%0d", k, g_dut[0].vif.hcount);
        check("re-enable latency", 32'(k), 32'd4);
        check("re-enable hcount",  32'(g_dut[0].vif.hcount), 32'd11);

        // Async reset while hsync is active
        wait_pix(19, 3, 200);
        @(posedge ACLK);
        #1 ARESETN = 1'b0;
        #1;
        $display("mid-frame reset: hsync=%0b hcount=%0d frame_cnt=%0d",
                 g_dut[0].vif.hsync, g_dut[0].vif.hcount, g_dut[0].vif.frame_cnt);
        check("async rst d0 hsync",     32'(g_dut[0].vif.hsync), 32'd1);
        check("async rst d0 hcount",    32'(g_dut[0].vif.hcount), 32'd0);
        check("async rst d0 frame_cnt", 32'(g_dut[0].vif.frame_cnt), 32'd0);
        check("async rst d1 hsync",     32'(g_dut[1].vif.hsync), 32'd0);
        repeat (3) @(negedge ACLK);
        #2 ARESETN = 1'b1;
        k = 0;
        for (int i = 1; i <= 20 && k == 0; i++) begin
            @(negedge ACLK);
            if (g_dut[0].vif.pix_en) k = i;
        end
        $display("post-reset: first pix_en after %0d cycles, frame_start=%0b",
                 k, g_dut[0].vif.frame_start);
        check("post-reset first tick",  32'(k), 32'd4);
        check("post-reset frame_start", 32'(g_dut[0].vif.frame_start), 32'd1);
        repeat (100) @(negedge ACLK);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA raster timing (pixel enable, h/v counters, syncs, blanking, frame/line strobes) from ACLK.
- Sits directly upstream of the character/rectangle draw IP, which samples all outputs when pix_en=1 and overlays text-memory characters.
- Default timing is 640x480@60 Hz: 25 MHz pixel rate from a 100 MHz ACLK.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 4, ACLK cycles per pixel (>=1)
SYNC_POL, 0, sync polarity: 0 = active-low, 1 = active-high

Ports:
ACLK  in  1  system clock
ARESETN  in  1  asynchronous active-low reset
enable  in  1  run raster; 0 freezes position
pix_en  out  1  one-ACLK strobe; outputs carry a new pixel
hcount  out  11  current pixel column, 0..H_TOTAL-1
vcount  out  11  current line, 0..V_TOTAL-1
hsync  out  1  horizontal sync, polarity per SYNC_POL
vsync  out  1  vertical sync, polarity per SYNC_POL
hblnk  out  1  high when hcount >= H_ACTIVE
vblnk  out  1  high when vcount >= V_ACTIVE
active  out  1  !hblnk && !vblnk
line_start  out  1  high with pix_en when hcount==0
frame_start  out  1  high with pix_en when hcount==0 and vcount==0
frame_cnt  out  16  completed-frame counter

Behaviour:
- Derived constants: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Reset (async on ARESETN low, released synchronously to ACLK):
  - Internal h position = H_TOTAL-1; internal v position = V_TOTAL-1; div counter = 0.
  - Outputs: hcount=0, vcount=0, hsync=vsync=!SYNC_POL; pix_en, hblnk, vblnk, active, line_start, frame_start = 0; frame_cnt = 0.
- Divider:
  - While enable=1, div counts 0..CLK_DIV-1 and wraps.
  - Internal tick = enable && div==CLK_DIV-1. With CLK_DIV=1, tick = enable on every cycle.
- On tick:
  - h <= (h==H_TOTAL-1) ? 0 : h+1.
  - v advances only when h wraps: v <= (v==V_TOTAL-1) ? 0 : v+1.
  - All outputs are registered from the NEW h/v on the same edge, and pix_en is set for that one cycle.
  - Net latency: tick to visible outputs = 1 ACLK.
- Decode from new h/v:
  - hsync asserted (==SYNC_POL) for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - vsync asserted for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491.
  - hblnk, vblnk and active as defined in Ports.
  - line_start = (h==0); frame_start = (h==0 && v==0). Both are valid only while pix_en=1 and are 0 otherwise.
- First tick after reset yields hcount=0, vcount=0, frame_start=1.
- Non-tick cycles: pix_en, line_start, frame_start = 0. hcount, vcount, syncs, blanks and active hold their values.
- frame_cnt:
  - Increments by 1 on each tick that produces frame_start, except the first frame_start after reset.
  - Wraps 0xFFFF -> 0x0000.
- enable=0:
  - div cleared to 0; no ticks; all level outputs hold; strobes 0.
  - On re-enable, the first tick occurs CLK_DIV cycles later and resumes from the held position (no restart).
- Reset asserted mid-frame: immediate return to reset values regardless of enable or divider phase.

Test Plan:
- Reset release, enable=1, defaults -> first pix_en at the 4th ACLK after enable; hcount=0, vcount=0, frame_start=1, hsync=vsync=1; pix_en thereafter every 4 cycles exactly.
- Run one full line -> hsync=0 for hcount 656..751 only; hblnk=1 for 640..799; at hcount 799->0, vcount increments 0->1 and line_start=1.
- Run 2 full frames -> vsync=0 for vcount 490..491 (1600 pixel ticks); vblnk=1 for 480..524; frame_start exactly once per 420000 ticks; frame_cnt 0->1 at second frame_start.
- Drop enable at hcount=300, vcount=100 for 50 cycles, then re-raise -> outputs hold (hcount=300), pix_en=0 throughout; next pix_en CLK_DIV cycles after re-enable with hcount=301.
- Assert ARESETN low at hcount=700 (hsync active) -> same-cycle async clear: hsync=1, hcount=0, frame_cnt=0; after release, first tick gives frame_start=1.
- CLK_DIV=1, SYNC_POL=1 build -> pix_en high every enabled cycle; hsync=1 only in 656..751; reset value hsync=0.
